// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants, state encoding and helper for the serial
//                BCD adder (bcd_serial_adder / bcd_digit_adder).
//  Contents    : BCD_MAX, BCD_ADJ, state_t, nines_comp()
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    // Largest legal decimal digit and the correction added when a digit sum
    // overflows past 9 (skips the six unused 4-bit codes).
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nines-complement of one BCD digit. Legal digits map to legal digits and
    // illegal digits (10..15) wrap to illegal digits (15..10).
    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adder
//  Description : Combinational single-digit BCD adder with decimal correction.
//  Ports       : a, b    - BCD digits in
//                cin     - carry in
//                digit   - corrected BCD digit out
//                cout    - decimal carry out
//                err     - either input digit is above 9
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout,
    output logic       err
);

    logic [4:0] w_sum;

    always_comb begin
        w_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        digit = w_sum[3:0];
        cout  = 1'b0;
        // Binary sum beyond 9: add 6 so the low nibble wraps into decimal.
        if (w_sum > {1'b0, BCD_MAX}) begin
            digit = w_sum[3:0] + BCD_ADJ;
            cout  = 1'b1;
        end
        err = (a > BCD_MAX) | (b > BCD_MAX);
    end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_adder
//  Description : N-digit BCD adder, one digit per clock, LSD first, with a
//                registered digit carry. Valid/ready on both sides; the
//                registered result feeds the BCD-to-FND decoder.
//  Ports       : clk, reset (sync, active-high)
//                A, B, C_in, i_valid, o_ready      - operand side
//                i_sum, carry, o_err, o_valid, i_ready - result side
//                i_sub (only with BCD_SERIAL_ADDER_SUBTRACT_EN) - A - B
//  Options     : `define BCD_SERIAL_ADDER_SUBTRACT_EN adds ten's-complement
//                subtraction (carry = 1 means no borrow).
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] A,
    input  logic [4*DIGITS-1:0] B,
    input  logic                C_in,
`ifdef BCD_SERIAL_ADDER_SUBTRACT_EN
    input  logic                i_sub,
`endif
    input  logic                i_valid,
    output logic                o_ready,
    output logic [4*DIGITS-1:0] i_sum,
    output logic                carry,
    output logic                o_err,
    output logic                o_valid,
    input  logic                i_ready
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W     = 4 * DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ADD  = ADD;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_res;
    logic [IDX_W-1:0] r_idx;
    logic             r_cy;
    logic             r_err_acc;
`ifdef BCD_SERIAL_ADDER_SUBTRACT_EN
    logic             r_sub;
`endif

    logic [3:0]   w_a_dig;
    logic [3:0]   w_b_raw;
    logic [3:0]   w_b_dig;
    logic [3:0]   w_digit;
    logic         w_cout;
    logic         w_add_err;
    logic         w_err;
    logic [W-1:0] w_res_next;
    logic         w_cin_first;

    // Digit mux: the single adder cell works on digit r_idx of each operand.
    assign w_a_dig = r_a[4*r_idx +: 4];
    assign w_b_raw = r_b[4*r_idx +: 4];

`ifdef BCD_SERIAL_ADDER_SUBTRACT_EN
    assign w_b_dig     = r_sub ? nines_comp(w_b_raw) : w_b_raw;
    // Subtraction is A + nines(B) + 1, so the initial carry is forced.
    assign w_cin_first = i_sub ? 1'b1 : C_in;
`else
    assign w_b_dig     = w_b_raw;
    assign w_cin_first = C_in;
`endif

    bcd_digit_adder u_digit (
        .a     (w_a_dig),
        .b     (w_b_dig),
        .cin   (r_cy),
        .digit (w_digit),
        .cout  (w_cout),
        .err   (w_add_err)
    );

    // The error flag must reflect the original B digit, not its complement.
    assign w_err = w_add_err | (w_b_raw > BCD_MAX);

    always_comb begin
        w_res_next              = r_res;
        w_res_next[4*r_idx +: 4] = w_digit;
    end

    assign o_ready = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_idx     <= '0;
            r_cy      <= 1'b0;
            r_err_acc <= 1'b0;
`ifdef BCD_SERIAL_ADDER_SUBTRACT_EN
            r_sub     <= 1'b0;
`endif
            i_sum     <= '0;
            carry     <= 1'b0;
            o_err     <= 1'b0;
            o_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_cy      <= w_cin_first;
`ifdef BCD_SERIAL_ADDER_SUBTRACT_EN
                        r_sub     <= i_sub;
`endif
                        r_res     <= '0;
                        r_idx     <= '0;
                        r_err_acc <= 1'b0;
                        r_state   <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_res     <= w_res_next;
                    r_cy      <= w_cout;
                    r_err_acc <= r_err_acc | w_err;
                    if (r_idx == LAST_IDX) begin
                        // Publish the whole word at once so the display
                        // never sees a partially built result.
                        i_sum   <= w_res_next;
                        carry   <= w_cout;
                        o_err   <= r_err_acc | w_err;
                        o_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_adder
//  Description : Directed self-checking bench for bcd_serial_adder (DIGITS=4)
//                with a queue of expected results.
//  Options     : BCD_SERIAL_ADDER_SUBTRACT_EN enables the subtract vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cy;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_in;
`ifdef BCD_SERIAL_ADDER_SUBTRACT_EN
    logic         i_sub;
`endif
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_sum;
    logic         carry;
    logic         o_err;
    logic         o_valid;
    logic         i_ready;

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t sb[$];

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .C_in    (C_in),
`ifdef BCD_SERIAL_ADDER_SUBTRACT_EN
        .i_sub   (i_sub),
`endif
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sum   (i_sum),
        .carry   (carry),
        .o_err   (o_err),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers one operation and pushes its expected result.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] esum, input logic ecy,
                        input logic eerr);
        exp_t e;
        A = a; B = b; C_in = cin; i_valid = 1'b1;
`ifdef BCD_SERIAL_ADDER_SUBTRACT_EN
        i_sub = sub;
`endif
        check("ready_before_accept", 32'(o_ready), 32'd1);
        e.sum = esum; e.cy = ecy; e.err = eerr;
        sb.push_back(e);
        tick();
        i_valid = 1'b0;
        A = 16'hFFFF; B = 16'hFFFF; C_in = 1'b1;
`ifdef BCD_SERIAL_ADDER_SUBTRACT_EN
        i_sub = ~sub;
`endif
    endtask

    // Waits for o_valid, checks latency and ready, compares against the queue.
    task automatic collect(input string tag);
        int   edges = 0;
        logic rdy_seen = 1'b0;
        exp_t e;
        while (!o_valid && edges < 20) begin
            rdy_seen = rdy_seen | o_ready | o_valid;
            tick();
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'(DIGITS));
        check({tag, "_busy_ready"}, 32'(rdy_seen), 32'd0);
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        e = sb.pop_front();
        check({tag, "_sum"}, 32'(i_sum), 32'(e.sum));
        check({tag, "_carry"}, 32'(carry), 32'(e.cy));
        check({tag, "_err"}, 32'(o_err), 32'(e.err));
    endtask

    task automatic release_result(input string tag);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check({tag, "_valid_clr"}, 32'(o_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; A = '0; B = '0; C_in = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
`ifdef BCD_SERIAL_ADDER_SUBTRACT_EN
        i_sub = 1'b0;
`endif
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_sum",   32'(i_sum),   32'd0);
        check("rst_carry", 32'(carry),   32'd0);
        check("rst_err",   32'(o_err),   32'd0);

        send(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
        collect("add1234");
        release_result("add1234");

        send(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        collect("cin_only");
        release_result("cin_only");

        // 9999 + 1 then hold the result with i_ready low
        send(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        collect("add9999");
        for (int k = 0; k < 10; k++) begin
            A = 16'h4444; B = 16'h4444; i_valid = k[0];
            tick();
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_sum",   32'(i_sum),   32'h0000);
            check("hold_carry", 32'(carry),   32'd1);
            check("hold_ready", 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        release_result("add9999");

        // Invalid digit then a clean operation
        send(16'h000A, 16'h0001, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b1);
        collect("bad_digit");
        release_result("bad_digit");
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        collect("after_bad");
        release_result("after_bad");

        // Reset in the second ADD cycle aborts the operation
        A = 16'h5555; B = 16'h5555; C_in = 1'b0; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_sum",   32'(i_sum),   32'd0);
        check("abort_ready", 32'(o_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("abort_no_result", 32'(o_valid), 32'd0);
        end
        send(16'h5555, 16'h5555, 1'b0, 1'b0, 16'h1110, 1'b1, 1'b0);
        collect("add5555");
        release_result("add5555");

`ifdef BCD_SERIAL_ADDER_SUBTRACT_EN
        send(16'h0100, 16'h0001, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0);
        collect("sub_nb");
        release_result("sub_nb");
        send(16'h0001, 16'h0002, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0);
        collect("sub_borrow");
        release_result("sub_borrow");
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
